apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 35 +++
 rtl/apb_master_arb.sv | 129 ++++++++++++
 tb/tb_apb_master_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master.
//   apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   NREQ        : number of requesters sharing the APB master
package apb_pkg;

    localparam int unsigned NREQ = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock and asynchronous active-high reset
//   req      : request bits, one per requester
//   advance  : the current grant is being taken; remember who won
//   grant    : one-hot grant (combinational), all-zero when no request
module rr_arb2
    import apb_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    // Index of the requester granted most recently. Reset to 1 so that
    // requester 0 wins the first contention.
    logic last_q;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_q <= grant[1];
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// APB master shared by two requesters through a round-robin arbiter.
//   PCLK, PRESET           : clock, asynchronous active-high reset
//   req_valid/write/addr/wdata : per-requester commands (packed, slice n = requester n)
//   req_done               : one-cycle completion pulse to the granted requester
//   req_rdata, req_err     : read data / error, valid while req_done is non-zero
//   PSEL..PWDATA           : registered APB master outputs
//   PRDATA, PREADY, PSLVERR: APB slave response
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]      req_rdata,
    output logic                       req_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH-1:0]      PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR
);

    // One spare bit is kept when the timeout is disabled so the counter never
    // collapses to zero width.
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    apb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  arb_req, arb_grant;
    logic             advance;
    logic             gidx;
    logic             timeout;
    logic             finish;

    // A requester whose done pulse is showing cannot be re-granted this cycle.
    assign arb_req = req_valid & ~req_done;
    assign gidx    = arb_grant[1];

    rr_arb2 u_arb (
        .clk     (PCLK),
        .rst     (PRESET),
        .req     (arb_req),
        .advance (advance),
        .grant   (arb_grant)
    );

    assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST) && !PREADY;
    assign finish  = (state_q == ACCESS) && (PREADY || timeout);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_req != 2'b00) begin
                    state_d = SETUP;
                    advance = 1'b1;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (finish) begin
                    state_d = IDLE;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            PSEL    <= (state_d != IDLE);
            PENABLE <= (state_d == ACCESS);
            // Command is captured once at grant and held for the whole transfer.
            if (advance) begin
                gnt_q  <= arb_grant;
                PWRITE <= req_write[gidx];
                PADDR  <= gidx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : req_addr[ADDR_WIDTH-1:0];
                PWDATA <= gidx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];
            end
        end
    end

    // Completion is reported in the ACCESS cycle that ends the transfer; a
    // timeout always reports an error with zero data.
    always_comb begin
        req_done  = finish ? gnt_q : '0;
        req_err   = finish && (!PREADY || PSLVERR);
        req_rdata = '0;
        if ((state_q == ACCESS) && PREADY && !PWRITE) begin
            req_rdata = PRDATA;
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed table, corner-case
// sequences (timeout, reset mid-ACCESS) and randomized transfers checked
// against a transaction-level model of memory contents and arbitration order.
module tb_apb_master_arb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [1:0]      req_valid, req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_done;
    logic [DW-1:0]   req_rdata;
    logic            req_err;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA, PRDATA;
    logic            PREADY, PSLVERR;

    apb_master_arb #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_err   (req_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    int          wait_cfg = 0;
    bit          err_cfg  = 1'b0;
    bit          hang     = 1'b0;
    bit          init_req = 1'b0;
    int          acc_cnt  = 0;
    logic [31:0] slv_mem [32];

    function automatic logic [31:0] init_val(input int i);
        return 32'h9c4e9a31 ^ (32'(i) * 32'h01010101);
    endfunction

    assign PREADY  = PSEL && PENABLE && !hang && (acc_cnt >= wait_cfg);
    assign PSLVERR = PREADY && err_cfg;
    assign PRDATA  = (PREADY && !PWRITE) ? slv_mem[PADDR] : 32'hdeadbeef;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge PCLK) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) slv_mem[i] <= init_val(i);
        end else if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) begin
            slv_mem[PADDR] <= PWDATA;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic [1:0]  mask;
        cmd_t        c0;
        cmd_t        c1;
        int          wt;
        bit          er;
        int          first;
        logic [31:0] rd0;
        logic [31:0] rd1;
        bit          e0;
        bit          e1;
        int          lat0;
        int          lat1;
    } vec_t;

    function automatic cmd_t mkcmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = d;
        return c;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] model_mem [32];
    int          last_gnt = 1;
    int          exp_first;
    logic [31:0] exp_rd  [2];
    bit          exp_err [2];
    int          exp_lat [2];

    // Serve the requests in round-robin order; each transfer takes 3+wt
    // cycles and the second one starts after a pass through IDLE.
    task automatic predict(input logic [1:0] mask, input cmd_t c0, input cmd_t c1,
                           input int wt, input bit er);
        int order [2];
        int cnt;
        int n;
        cmd_t c;
        if (mask == 2'b11) begin
            order[0] = (last_gnt == 0) ? 1 : 0;
            order[1] = 1 - order[0];
            cnt = 2;
        end else begin
            order[0] = mask[1] ? 1 : 0;
            order[1] = 0;
            cnt = 1;
        end
        exp_first = order[0];
        for (int k = 0; k < 2; k++) begin
            exp_rd[k] = '0; exp_err[k] = 1'b0; exp_lat[k] = -1;
        end
        for (int k = 0; k < cnt; k++) begin
            n = order[k];
            c = (n == 1) ? c1 : c0;
            exp_lat[n] = (k == 0) ? 2 + wt : 5 + 2 * wt;
            exp_err[n] = er;
            if (c.wr) begin
                exp_rd[n] = '0;
                if (!er) model_mem[c.addr] = c.wdata;
            end else begin
                exp_rd[n] = model_mem[c.addr];
            end
            last_gnt = n;
        end
    endtask

    // ---------------- transaction driver / monitor ----------------
    bit          got_seen [2];
    logic [31:0] got_rd   [2];
    bit          got_err  [2];
    int          got_lat  [2];
    bit          proto_bad, unstable, spurious, setup_bad;

    task automatic do_txn(input logic [1:0] mask, input cmd_t c0, input cmd_t c1,
                          input int wt, input bit er, input int first);
        int start;
        int cur;
        cmd_t cc;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic sw;
        wait_cfg = wt;
        err_cfg  = er;
        for (int n = 0; n < 2; n++) begin
            got_seen[n] = 1'b0; got_rd[n] = '0; got_err[n] = 1'b0; got_lat[n] = -1;
        end
        proto_bad = 1'b0; unstable = 1'b0; spurious = 1'b0; setup_bad = 1'b0;
        sa = '0; sd = '0; sw = 1'b0;
        req_write = {c1.wr, c0.wr};
        req_addr  = {c1.addr, c0.addr};
        req_wdata = {c1.wdata, c0.wdata};
        req_valid = mask;
        start = cyc;
        cur = first;
        for (int k = 0; k < 100 && req_valid != 2'b00; k++) begin
            @(negedge PCLK);
            if (PENABLE && !PSEL) proto_bad = 1'b1;
            if (PSEL && !PENABLE) begin
                cc = (cur == 1) ? c1 : c0;
                if (PADDR !== cc.addr || PWRITE !== cc.wr || PWDATA !== cc.wdata) setup_bad = 1'b1;
                sa = PADDR; sd = PWDATA; sw = PWRITE;
                // Disturb the granted command; the transfer must not notice.
                if (cur == 1) begin
                    req_addr[2*AW-1:AW]  = ~cc.addr;
                    req_wdata[2*DW-1:DW] = ~cc.wdata;
                    req_write[1]         = ~cc.wr;
                end else begin
                    req_addr[AW-1:0]  = ~cc.addr;
                    req_wdata[DW-1:0] = ~cc.wdata;
                    req_write[0]      = ~cc.wr;
                end
            end
            if (PSEL && PENABLE && (PADDR !== sa || PWDATA !== sd || PWRITE !== sw)) unstable = 1'b1;
            for (int n = 0; n < 2; n++) begin
                if (req_done[n]) begin
                    if (!req_valid[n] || got_seen[n]) begin
                        spurious = 1'b1;
                    end else begin
                        got_seen[n] = 1'b1;
                        got_rd[n]   = req_rdata;
                        got_err[n]  = req_err;
                        got_lat[n]  = cyc - start;
                    end
                    req_valid[n] = 1'b0;
                end
            end
            if (req_done != 2'b00) cur = 1 - cur;
        end
        if (req_valid != 2'b00) begin
            chk("txn_bound", req_valid, 2'b00);
            req_valid = 2'b00;
        end
        @(negedge PCLK);
    endtask

    task automatic check_res(input string tag, input logic [1:0] mask);
        for (int n = 0; n < 2; n++) begin
            if (mask[n]) begin
                chk($sformatf("%s_r%0d_done", tag, n), got_seen[n], 1'b1);
                chk($sformatf("%s_r%0d_rdata", tag, n), got_rd[n], exp_rd[n]);
                chk($sformatf("%s_r%0d_err", tag, n), got_err[n], exp_err[n]);
                chk($sformatf("%s_r%0d_lat", tag, n), got_lat[n], exp_lat[n]);
            end else begin
                chk($sformatf("%s_r%0d_nodone", tag, n), got_seen[n], 1'b0);
            end
        end
        chk({tag, "_penable_wo_psel"}, proto_bad, 1'b0);
        chk({tag, "_setup_cmd"}, setup_bad, 1'b0);
        chk({tag, "_access_stable"}, unstable, 1'b0);
        chk({tag, "_spurious_done"}, spurious, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c0, c1;
        logic [1:0] mask;
        int wt;
        bit er;

        tbl[0] = '{mask: 2'b11, c0: mkcmd(1'b1, 5'h10, 32'h11223344), c1: mkcmd(1'b0, 5'h10, 32'h0),
                   wt: 0, er: 1'b0, first: 0, rd0: 32'h0, rd1: 32'h11223344,
                   e0: 1'b0, e1: 1'b0, lat0: 2, lat1: 5};
        tbl[1] = '{mask: 2'b01, c0: mkcmd(1'b0, 5'h00, 32'h0), c1: mkcmd(1'b0, 5'h00, 32'h0),
                   wt: 0, er: 1'b0, first: 0, rd0: 32'h9c4e9a31, rd1: 32'h0,
                   e0: 1'b0, e1: 1'b0, lat0: 2, lat1: -1};
        tbl[2] = '{mask: 2'b10, c0: mkcmd(1'b0, 5'h00, 32'h0), c1: mkcmd(1'b0, 5'h03, 32'h0),
                   wt: 4, er: 1'b0, first: 1, rd0: 32'h0, rd1: 32'h9f4d9932,
                   e0: 1'b0, e1: 1'b0, lat0: -1, lat1: 6};
        tbl[3] = '{mask: 2'b01, c0: mkcmd(1'b1, 5'h1c, 32'hcafef00d), c1: mkcmd(1'b0, 5'h00, 32'h0),
                   wt: 0, er: 1'b1, first: 0, rd0: 32'h0, rd1: 32'h0,
                   e0: 1'b1, e1: 1'b0, lat0: 2, lat1: -1};
        tbl[4] = '{mask: 2'b11, c0: mkcmd(1'b0, 5'h1c, 32'h0), c1: mkcmd(1'b1, 5'h05, 32'ha5a5a5a5),
                   wt: 1, er: 1'b0, first: 1, rd0: 32'h8052862d, rd1: 32'h0,
                   e0: 1'b0, e1: 1'b0, lat0: 7, lat1: 3};

        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        init_req  = 1'b1;
        for (int i = 0; i < 32; i++) model_mem[i] = init_val(i);
        repeat (2) @(negedge PCLK);
        init_req = 1'b0;

        chk("reset_psel", PSEL, 1'b0);
        chk("reset_penable", PENABLE, 1'b0);
        chk("reset_pwrite", PWRITE, 1'b0);
        chk("reset_paddr", PADDR, '0);
        chk("reset_pwdata", PWDATA, '0);
        chk("reset_req_done", req_done, 2'b00);
        chk("reset_req_rdata", req_rdata, '0);
        chk("reset_req_err", req_err, 1'b0);
        PRESET = 1'b0;

        for (int v = 0; v < 5; v++) begin
            predict(tbl[v].mask, tbl[v].c0, tbl[v].c1, tbl[v].wt, tbl[v].er);
            exp_rd[0]  = tbl[v].rd0;  exp_rd[1]  = tbl[v].rd1;
            exp_err[0] = tbl[v].e0;   exp_err[1] = tbl[v].e1;
            exp_lat[0] = tbl[v].lat0; exp_lat[1] = tbl[v].lat1;
            do_txn(tbl[v].mask, tbl[v].c0, tbl[v].c1, tbl[v].wt, tbl[v].er, tbl[v].first);
            check_res($sformatf("vec%0d", v), tbl[v].mask);
        end

        // Timeout: slave never ready.
        hang = 1'b1;
        c0 = mkcmd(1'b0, 5'h07, 32'h0);
        predict(2'b01, c0, c0, 0, 1'b1);
        exp_rd[0] = '0; exp_err[0] = 1'b1; exp_lat[0] = TO + 1;
        do_txn(2'b01, c0, c0, 0, 1'b0, 0);
        hang = 1'b0;
        check_res("timeout", 2'b01);
        chk("timeout_psel_after", {PSEL, PENABLE}, 2'b00);

        // Reset in the middle of ACCESS.
        hang = 1'b1;
        req_write = 2'b00;
        req_addr  = {5'h00, 5'h02};
        req_valid = 2'b01;
        repeat (2) @(negedge PCLK);
        chk("rst_pre_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1;
        chk("rst_async_psel", {PSEL, PENABLE}, 2'b00);
        chk("rst_async_done", req_done, 2'b00);
        req_valid = 2'b00;
        @(negedge PCLK);
        chk("rst_no_done", req_done, 2'b00);
        PRESET = 1'b0;
        hang = 1'b0;
        last_gnt = 1;
        c0 = mkcmd(1'b0, 5'h02, 32'h0);
        c1 = mkcmd(1'b0, 5'h04, 32'h0);
        predict(2'b11, c0, c1, 0, 1'b0);
        do_txn(2'b11, c0, c1, 0, 1'b0, exp_first);
        check_res("post_rst", 2'b11);

        // Randomized transfers against the model.
        for (int it = 0; it < 40; it++) begin
            c0   = mkcmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            c1   = mkcmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
            mask = 2'($urandom_range(1, 3));
            wt   = $urandom_range(0, 3);
            er   = ($urandom_range(0, 3) == 0);
            predict(mask, c0, c1, wt, er);
            do_txn(mask, c0, c1, wt, er, exp_first);
            check_res($sformatf("rand%0d", it), mask);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
